// File: rtl/pipe_pkg.sv
// pipe_pkg: shared slot state encoding and bubble payload for the elastic pipeline.
package pipe_pkg;
    typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_t;
    localparam int PIPE_MAX_W = 1024;
    localparam logic [PIPE_MAX_W-1:0] PIPE_BUBBLE = '0;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one elastic register slot; PIPE_SKID_EN adds a skid entry so in_ready is registered.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    pipe_state_t state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic in_fire, out_fire;
`ifdef PIPE_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;
    assign in_ready = state_q != PS_TWO;
`else
    assign in_ready = state_q == PS_EMPTY || out_ready;
`endif
    assign out_valid = state_q != PS_EMPTY;
    assign out_data  = main_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = PS_EMPTY;
            main_d  = PIPE_BUBBLE[WIDTH-1:0];
`ifdef PIPE_SKID_EN
            skid_d  = PIPE_BUBBLE[WIDTH-1:0];
`endif
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (in_fire) begin
                        state_d = PS_ONE;
                        main_d  = in_data;
                    end
                end
                PS_ONE: begin
`ifdef PIPE_SKID_EN
                    // Parked entry goes to skid so main keeps presenting the head.
                    if (in_fire && !out_fire) begin
                        state_d = PS_TWO;
                        skid_d  = in_data;
                    end else
`endif
                    if (in_fire) main_d = in_data;
                    else if (out_fire) state_d = PS_EMPTY;
                end
`ifdef PIPE_SKID_EN
                PS_TWO: begin
                    if (out_fire) begin
                        state_d = PS_ONE;
                        main_d  = skid_q;
                    end
                end
`endif
                default: state_d = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= PS_EMPTY;
            main_q  <= '0;
`ifdef PIPE_SKID_EN
            skid_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef PIPE_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end
endmodule

// File: rtl/pipe_elastic.sv
// pipe_elastic: DEPTH-slot valid/ready register chain with flush and occupancy count.
// Define PIPE_SKID_EN for two entries per slot and a registered in_ready.
module pipe_elastic
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    localparam int OCC_W = $clog2(2 * DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);
    logic             v [0:DEPTH];
    logic             r [0:DEPTH];
    logic [WIDTH-1:0] d [0:DEPTH];
    logic [OCC_W-1:0] occ_q, occ_d;
    logic in_fire, out_fire;

    assign v[0]      = in_valid;
    assign d[0]      = in_data;
    assign in_ready  = r[0];
    assign r[DEPTH]  = out_ready;
    assign out_valid = v[DEPTH];
    assign out_data  = d[DEPTH];
    assign occupancy = occ_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        pipe_slot #(.WIDTH(WIDTH)) u_slot (
            .clk      (clk),
            .clr      (clr),
            .flush    (flush),
            .in_valid (v[i]),
            .in_ready (r[i]),
            .in_data  (d[i]),
            .out_valid(v[i+1]),
            .out_ready(r[i+1]),
            .out_data (d[i+1])
        );
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign occ_d    = flush ? '0 : occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);

    always_ff @(posedge clk) begin
        if (clr) occ_q <= '0;
        else     occ_q <= occ_d;
    end
endmodule

// File: tb/tb_pipe_elastic.sv
// tb_pipe_elastic: directed and random checks of pipe_elastic at DEPTH 1, 2 and 3.
// Expectations follow PIPE_SKID_EN when the bench is built with it.
module tb_pipe_elastic;
    logic clk = 1'b0;
    logic clr = 1'b1;
    logic        iv [1:3];
    logic        ir [1:3];
    logic        ov [1:3];
    logic        orr[1:3];
    logic        fl [1:3];
    logic [31:0] id [1:3];
    logic [31:0] od [1:3];
    logic [1:0]  occ1;
    logic [2:0]  occ2, occ3;
    logic [31:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int mocc = 0;
    int max_occ = 0;
    int fill;
    logic last_in_f, last_out_f;

    always #5 clk = ~clk;

    pipe_elastic #(.WIDTH(32), .DEPTH(1)) u_d1 (
        .clk(clk), .clr(clr), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1]), .occupancy(occ1));
    pipe_elastic #(.WIDTH(32), .DEPTH(2)) u_d2 (
        .clk(clk), .clr(clr), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od[2]), .occupancy(occ2));
    pipe_elastic #(.WIDTH(32), .DEPTH(3)) u_d3 (
        .clk(clk), .clr(clr), .flush(fl[3]), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id[3]),
        .out_valid(ov[3]), .out_ready(orr[3]), .out_data(od[3]), .occupancy(occ3));

    function automatic logic [31:0] occ_of(input int k);
        return k == 1 ? 32'(occ1) : k == 2 ? 32'(occ2) : 32'(occ3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // One clock of stimulus on instance k; scoreboard pops on out fire, pushes on in fire.
    task automatic step(input int k, input logic v, input logic [31:0] d, input logic r, input logic f);
        logic inf, outf;
        @(posedge clk);
        #1;
        iv[k] = v; id[k] = d; orr[k] = r; fl[k] = f;
        #1;
        chk("occ", occ_of(k), 32'(mocc));
        if (int'(occ_of(k)) > max_occ) max_occ = int'(occ_of(k));
        inf = iv[k] & ir[k];
        outf = ov[k] & orr[k];
        last_in_f = inf;
        last_out_f = outf;
        if (f) begin
            exp_q.delete();
            mocc = 0;
        end else begin
            if (outf) begin
                chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("data", od[k], exp_q.pop_front());
            end
            if (inf) exp_q.push_back(d);
            mocc = mocc + int'(inf) - int'(outf);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 1; k <= 3; k++) begin
            iv[k] = 1'b1; id[k] = 32'hDEADBEEF; orr[k] = 1'b0; fl[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        for (int k = 1; k <= 3; k++) iv[k] = 1'b0;
        #1;
        for (int k = 1; k <= 3; k++) begin
            chk("rst_ov", 32'(ov[k]), 0);
            chk("rst_od", od[k], 0);
            chk("rst_occ", occ_of(k), 0);
            chk("rst_ir", 32'(ir[k]), 1);
        end

        // Streaming through DEPTH=3
        max_occ = 0;
        for (int s = 0; s < 10; s++) begin
            step(3, s < 5, 32'(s + 1), 1'b1, 1'b0);
            chk("st_out_valid", 32'(last_out_f), 32'(s >= 3 && s <= 7));
        end
        chk("st_peak_occ", 32'(max_occ), 3);

        // Backpressure on DEPTH=1
        step(1, 1'b1, 32'hA, 1'b0, 1'b0);
        step(1, 1'b1, 32'hB, 1'b0, 1'b0);
`ifdef PIPE_SKID_EN
        chk("bp_accept_b", 32'(last_in_f), 1);
        step(1, 1'b0, 0, 1'b0, 1'b0);
        chk("bp_full_ready", 32'(ir[1]), 0);
        step(1, 1'b0, 0, 1'b1, 1'b0);
        chk("bp_ready_in_pop", 32'(ir[1]), 0);
        step(1, 1'b0, 0, 1'b1, 1'b0);
        chk("bp_ready_after_pop", 32'(ir[1]), 1);
`else
        chk("bp_refuse_b", 32'(last_in_f), 0);
        step(1, 1'b0, 0, 1'b1, 1'b0);
`endif
        step(1, 1'b0, 0, 1'b0, 1'b0);

        // Simultaneous fire at full on DEPTH=1
        step(1, 1'b1, 32'h11, 1'b0, 1'b0);
        step(1, 1'b1, 32'h22, 1'b1, 1'b0);
        chk("sim_ready", 32'(ir[1]), 1);
        step(1, 1'b0, 0, 1'b0, 1'b0);
        chk("sim_data", od[1], 32'h22);
        chk("sim_occ", occ_of(1), 1);
        step(1, 1'b0, 0, 1'b1, 1'b0);
        step(1, 1'b0, 0, 1'b0, 1'b0);

        // Flush with entries held on DEPTH=2
`ifdef PIPE_SKID_EN
        fill = 3;
`else
        fill = 2;
`endif
        for (int i = 0; i < 8 && mocc < fill; i++) step(2, 1'b1, 32'h71 + 32'(i), 1'b0, 1'b0);
        step(2, 1'b0, 0, 1'b0, 1'b0);
        chk("fl_occ_before", occ_of(2), 32'(fill));
        step(2, 1'b1, 32'h77, 1'b0, 1'b1);
        step(2, 1'b0, 0, 1'b0, 1'b0);
        chk("fl_out_valid", 32'(ov[2]), 0);
        chk("fl_occ_after", occ_of(2), 0);
        repeat (5) step(2, 1'b0, 0, 1'b1, 1'b0);

        // Random valid/ready traffic
        for (int k = 1; k <= 3; k += 2) begin
            for (int i = 0; i < 3000; i++)
                step(k, 1'($urandom_range(1)), $urandom, $urandom_range(3) != 0, 1'b0);
            repeat (12) step(k, 1'b0, 0, 1'b1, 1'b0);
            chk("rnd_drained", 32'(exp_q.size()), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
